ddr4_cmd_scheduler: RTL and testbench

DDR4_CMD_SCHEDULER -- requirements
Module: ddr4_cmd_scheduler

---
 rtl/ddr4_cmd_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_ddr4_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_scheduler.sv
// Single-bank DDR4 command sequencer: one READ, WRITE or ROWCLONE request at a time,
// expanded into ACT/RD/WR/PRE commands with fixed tRCD/tCL/tRP spacing and registered outputs.
module ddr4_cmd_scheduler #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int TRP       = 15
) (
  input  logic                 ck_t,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [ADDRWIDTH-1:0] req_row2,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 writing,
  output logic                 rd_strobe,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLONE = 2'b10;

  localparam logic [ADDRWIDTH-1:0] A_WR  = ADDRWIDTH'(17'h10000);
  localparam logic [ADDRWIDTH-1:0] A_RD  = ADDRWIDTH'(17'h14000);
  localparam logic [ADDRWIDTH-1:0] A_PRE = ADDRWIDTH'(17'h08000);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD, S_CAS, S_WBURST, S_CLWAIT,
    S_RBURST, S_ACT2, S_RCD2, S_PRE, S_RP
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_cnt;
  logic [1:0]             r_op;
  logic [BGWIDTH-1:0]     r_cap_bg;
  logic [BAWIDTH-1:0]     r_cap_ba;
  logic [ADDRWIDTH-1:0]   r_row2;
  logic [COLWIDTH-1:0]    r_col;

  logic                   r_ready;
  logic                   r_cs_n;
  logic                   r_act_n;
  logic [ADDRWIDTH-1:0]   r_a;
  logic [BGWIDTH-1:0]     r_bg;
  logic [BAWIDTH-1:0]     r_ba;
  logic                   r_writing;
  logic                   r_rd_strobe;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  assign w_accept = r_ready & req_valid;

  // Outputs are registered for the state being entered, so each command
  // appears on the bus in the cycle right after the decision edge.
  always_ff @(posedge ck_t) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_cap_bg    <= '0;
      r_cap_ba    <= '0;
      r_row2      <= '0;
      r_col       <= '0;
      r_ready     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_act_n     <= 1'b1;
      r_a         <= '0;
      r_bg        <= '0;
      r_ba        <= '0;
      r_writing   <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later <= in the case overrides them.
      r_ready     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_act_n     <= 1'b1;
      r_a         <= '0;
      r_bg        <= r_cap_bg;
      r_ba        <= r_cap_ba;
      r_writing   <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_bg <= '0;
          r_ba <= '0;
          if (w_accept) begin
            r_op     <= req_op;
            r_cap_bg <= req_bg;
            r_cap_ba <= req_ba;
            r_row2   <= req_row2;
            r_col    <= req_col;
            if (req_op == 2'b11) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_ACT;
              r_cs_n  <= 1'b0;
              r_act_n <= 1'b0;
              r_a     <= req_row;
              r_bg    <= req_bg;
              r_ba    <= req_ba;
            end
          end else begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_ACT: begin
          r_state <= S_RCD;
          r_cnt   <= 8'(TRCD - 1);
        end
        S_RCD: begin
          if (r_cnt == '0) begin
            r_cs_n <= 1'b0;
            if (r_op == OP_CLONE) begin
              r_state <= S_ACT2;
              r_act_n <= 1'b0;
              r_a     <= r_row2;
            end else begin
              r_state   <= S_CAS;
              r_a       <= ((r_op == OP_WRITE) ? A_WR : A_RD) | ADDRWIDTH'(r_col);
              r_writing <= (r_op == OP_WRITE);
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_CAS: begin
          if (r_op == OP_READ) begin
            r_state <= S_CLWAIT;
            r_cnt   <= 8'(TCL - 1);
          end else if (BL == 1) begin
            r_state <= S_PRE;
            r_cs_n  <= 1'b0;
            r_a     <= A_PRE;
          end else begin
            r_state   <= S_WBURST;
            r_writing <= 1'b1;
            r_cnt     <= 8'(BL - 2);
          end
        end
        S_WBURST: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            r_cs_n  <= 1'b0;
            r_a     <= A_PRE;
          end else begin
            r_writing <= 1'b1;
            r_cnt     <= r_cnt - 8'd1;
          end
        end
        S_CLWAIT: begin
          if (r_cnt == '0) begin
            r_state     <= S_RBURST;
            r_rd_strobe <= 1'b1;
            r_cnt       <= 8'(BL - 1);
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RBURST: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            r_cs_n  <= 1'b0;
            r_a     <= A_PRE;
          end else begin
            r_rd_strobe <= 1'b1;
            r_cnt       <= r_cnt - 8'd1;
          end
        end
        S_ACT2: begin
          r_state <= S_RCD2;
          r_cnt   <= 8'(TRCD - 1);
        end
        S_RCD2: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            r_cs_n  <= 1'b0;
            r_a     <= A_PRE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_PRE: begin
          r_state <= S_RP;
          r_cnt   <= 8'(TRP - 1);
          r_bg    <= '0;
          r_ba    <= '0;
        end
        S_RP: begin
          r_bg <= '0;
          r_ba <= '0;
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign cs_n      = r_cs_n;
  assign act_n     = r_act_n;
  assign A         = r_a;
  assign bg        = r_bg;
  assign ba        = r_ba;
  assign writing   = r_writing;
  assign rd_strobe = r_rd_strobe;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Bench for ddr4_cmd_scheduler: directed and random requests compared every cycle
// against a schedule computed from the command timing rules.
module tb_ddr4_cmd_scheduler;

  localparam int BGW   = 2;
  localparam int BAW   = 2;
  localparam int AW    = 17;
  localparam int CW    = 10;
  localparam int BLEN  = 8;
  localparam int T_RCD = 15;
  localparam int T_CL  = 15;
  localparam int T_RP  = 15;

  typedef struct packed {
    logic [1:0]     op;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;
    logic [AW-1:0]  row;
    logic [AW-1:0]  row2;
    logic [CW-1:0]  col;
  } req_t;

  typedef struct packed {
    logic           cs_n;
    logic           act_n;
    logic [AW-1:0]  a;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;
    logic           wr;
    logic           rs;
    logic           busy;
    logic           done;
    logic           ready;
  } obs_t;

  logic           ck_t = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [BGW-1:0] req_bg;
  logic [BAW-1:0] req_ba;
  logic [AW-1:0]  req_row;
  logic [AW-1:0]  req_row2;
  logic [CW-1:0]  req_col;
  logic           cs_n;
  logic           act_n;
  logic [AW-1:0]  A;
  logic [BGW-1:0] bg;
  logic [BAW-1:0] ba;
  logic           writing;
  logic           rd_strobe;
  logic           busy;
  logic           done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  ddr4_cmd_scheduler #(
    .BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
    .BL(BLEN), .TRCD(T_RCD), .TCL(T_CL), .TRP(T_RP)
  ) dut (
    .ck_t(ck_t), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_row2(req_row2),
    .req_col(req_col),
    .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .writing(writing), .rd_strobe(rd_strobe), .busy(busy), .done(done)
  );

  always #5 ck_t = ~ck_t;

  function automatic obs_t observe();
    obs_t o;
    o.cs_n = cs_n;  o.act_n = act_n; o.a = A; o.bg = bg; o.ba = ba;
    o.wr = writing; o.rs = rd_strobe; o.busy = busy; o.done = done; o.ready = req_ready;
    return o;
  endfunction

  function automatic obs_t reset_vec();
    obs_t e;
    e = '0;
    e.cs_n = 1'b1;
    e.act_n = 1'b1;
    return e;
  endfunction

  function automatic obs_t idle_vec();
    obs_t e;
    e = reset_vec();
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic int pre_cycle(input logic [1:0] op);
    case (op)
      2'b00:   return T_RCD + T_CL + BLEN + 3;
      2'b01:   return T_RCD + BLEN + 2;
      2'b10:   return 2 * T_RCD + 3;
      default: return 0;
    endcase
  endfunction

  function automatic int done_cycle(input logic [1:0] op);
    if (op == 2'b11) return 1;
    return pre_cycle(op) + T_RP + 1;
  endfunction

  // Expected bus/status values in cycle t after the accept edge (cycle 0).
  function automatic obs_t model(input req_t r, input int t);
    obs_t e;
    int   pre;
    e = reset_vec();
    if (r.op == 2'b11) begin
      e.done  = 1'b1;
      e.ready = 1'b1;
      return e;
    end
    pre = pre_cycle(r.op);
    e.busy = 1'b1;
    if (t <= pre) begin
      e.bg = r.bg;
      e.ba = r.ba;
    end
    if (t == 1) begin
      e.cs_n = 1'b0; e.act_n = 1'b0; e.a = r.row;
    end
    if (t == T_RCD + 2) begin
      e.cs_n = 1'b0;
      if (r.op == 2'b10) begin
        e.act_n = 1'b0; e.a = r.row2;
      end else begin
        e.a[16:14] = (r.op == 2'b01) ? 3'b100 : 3'b101;
        e.a[CW-1:0] = r.col;
      end
    end
    if (t == pre) begin
      e.cs_n = 1'b0; e.a[16:14] = 3'b010;
    end
    e.wr = (r.op == 2'b01) && t >= T_RCD + 2 && t <= T_RCD + BLEN + 1;
    e.rs = (r.op == 2'b00) && t >= T_RCD + T_CL + 3 && t <= T_RCD + T_CL + BLEN + 2;
    if (t == pre + T_RP + 1) begin
      e.busy = 1'b0; e.done = 1'b1; e.ready = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input obs_t act, input obs_t exp, input string tag, input int t);
    n_chk++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, act, exp);
    end
  endtask

  task automatic drive(input req_t r);
    req_op = r.op; req_bg = r.bg; req_ba = r.ba;
    req_row = r.row; req_row2 = r.row2; req_col = r.col;
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.op   = 2'($urandom_range(0, 3));
    r.bg   = BGW'($urandom);
    r.ba   = BAW'($urandom);
    r.row  = AW'($urandom);
    r.row2 = AW'($urandom);
    r.col  = CW'($urandom);
    return r;
  endfunction

  // Called on a negedge with req_ready=1; returns on the negedge of the done
  // cycle (or of cycle abort_at, with reset raised).
  task automatic do_req(input req_t r, input bit keep, input req_t nxt,
                        input int abort_at, input string tag);
    int last;
    last = done_cycle(r.op);
    drive(r);
    req_valid = 1'b1;
    @(posedge ck_t);
    for (int t = 1; t <= last; t++) begin
      @(negedge ck_t);
      if (t == 1) begin
        if (keep) drive(nxt);
        else begin
          req_valid = 1'b0;
          drive(rand_req());
        end
      end
      check(observe(), model(r, t), tag, t);
      if (t == abort_at) begin
        reset = 1'b1;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck_t);
      @(negedge ck_t);
      check(observe(), idle_vec(), "idle", i);
    end
  endtask

  req_t w0, rd0, rc0, rsv, w1, w2, cur, nxt;
  bit   k;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    drive('0);
    repeat (3) @(posedge ck_t);
    @(negedge ck_t);
    check(observe(), reset_vec(), "reset_state", 0);
    reset = 1'b0;
    @(posedge ck_t);
    @(negedge ck_t);
    check(observe(), idle_vec(), "ready_after_reset", 0);
    idle(2);

    w0  = '{op: 2'b01, bg: 2'd1, ba: 2'd1, row: 17'd1, row2: 17'd0, col: 10'd2};
    rd0 = w0;  rd0.op = 2'b00;
    rc0 = '{op: 2'b10, bg: 2'd1, ba: 2'd1, row: 17'd1, row2: 17'd4, col: 10'd0};
    rsv = '{op: 2'b11, bg: 2'd3, ba: 2'd2, row: 17'h1ffff, row2: 17'h1ffff, col: 10'h3ff};

    do_req(w0, 1'b0, w0, 0, "write");
    idle(1);
    do_req(rd0, 1'b0, rd0, 0, "read");
    do_req(rc0, 1'b0, rc0, 0, "rowclone");
    do_req(rsv, 1'b0, rsv, 0, "reserved");
    idle(1);

    w1 = '{op: 2'b01, bg: 2'd2, ba: 2'd3, row: 17'h0abcd, row2: 17'h0, col: 10'h155};
    w2 = '{op: 2'b01, bg: 2'd1, ba: 2'd0, row: 17'h12345, row2: 17'h0, col: 10'h2aa};
    do_req(w1, 1'b1, w2, 0, "b2b_first");
    do_req(w2, 1'b0, w2, 0, "b2b_second");

    do_req(w0, 1'b0, w0, 20, "abort_write");
    for (int i = 0; i < 8; i++) begin
      @(posedge ck_t);
      @(negedge ck_t);
      check(observe(), reset_vec(), "abort_reset", 21 + i);
    end
    reset = 1'b0;
    @(posedge ck_t);
    @(negedge ck_t);
    check(observe(), idle_vec(), "abort_release", 0);
    idle(2);

    cur = rand_req();
    for (int i = 0; i < 14; i++) begin
      nxt = rand_req();
      k = (i < 13) && ($urandom_range(0, 1) == 1);
      do_req(cur, k, nxt, 0, "random");
      if (!k) idle($urandom_range(0, 2));
      cur = nxt;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
